// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the unified memory port between fetch and load/store
// Data wins by default; a streak limit guarantees fetch progress and a wait counter aborts hung accesses.
module mem_port_arbiter #(
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          IorD,
    output logic          mem_en,
    output logic          mem_we,
    output logic          if_done,
    output logic          ls_done,
    output logic [DW-1:0] rdata,
    output logic          timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] streak;
    logic          streak_full;
    logic          grant_data;

    // Fetch only overrides a pending data request once data has had its full streak.
    always_comb begin
        streak_full = (streak == SW'(MAX_STREAK));
        grant_data  = ls_req && !(if_req && streak_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            streak      <= '0;
            IorD        <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            if_done     <= 1'b0;
            ls_done     <= 1'b0;
            rdata       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_done     <= 1'b0;
            ls_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || ls_req) begin
                        state    <= S_ACCESS;
                        IorD     <= grant_data;
                        mem_en   <= 1'b1;
                        mem_we   <= grant_data && ls_we;
                        wait_cnt <= '0;
                        if (grant_data) begin
                            if (if_req && !streak_full)
                                streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // Done flags are raised on the exit edge so they are visible during RESP.
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_RESP;
                        if_done <= !IorD;
                        ls_done <= IorD;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        rdata       <= '0;
                        mem_en      <= 1'b0;
                        mem_we      <= 1'b0;
                        state       <= S_RESP;
                        if_done     <= !IorD;
                        ls_done     <= IorD;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        IorD;
    logic        mem_en;
    logic        mem_we;
    logic        if_done;
    logic        ls_done;
    logic [31:0] rdata;
    logic        timeout_err;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    logic        grant_q[$];
    int          checks = 0;
    int          failures = 0;
    int          mem_wait = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = '0;
    logic        mem_en_q = 1'b0;

    mem_port_arbiter #(.DW(32), .MAX_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .ls_req(ls_req), .ls_we(ls_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .IorD(IorD), .mem_en(mem_en),
        .mem_we(mem_we), .if_done(if_done), .ls_done(ls_done), .rdata(rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Memory model: ready after mem_wait cycles of mem_en (never when mem_wait < 0).
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) begin
                mem_ready = (mem_wait >= 0) && (mem_cnt == mem_wait);
                mem_cnt++;
            end else begin
                mem_ready = 1'b0;
                mem_cnt = 0;
            end
            mem_rdata = mem_data;
        end
    end

    // Scoreboard monitor and grant logger.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_en && !mem_en_q)
                grant_q.push_back(IorD);
            mem_en_q = mem_en;
            if (if_done || ls_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: if_done=%0b ls_done=%0b, required none", if_done, ls_done);
                end else begin
                    e = exp_q.pop_front();
                    if ({if_done, ls_done, rdata, timeout_err} !== {!e.is_data, e.is_data, e.data, e.tmo}) begin
                        failures++;
                        $display("FAIL done_result: if_done=%0b ls_done=%0b rdata=%h timeout_err=%0b, required if_done=%0b ls_done=%0b rdata=%h timeout_err=%0b",
                                 if_done, ls_done, rdata, timeout_err, !e.is_data, e.is_data, e.data, e.tmo);
                    end
                end
            end else if (timeout_err) begin
                checks++;
                failures++;
                $display("FAIL lone_timeout_err: timeout_err=1 without done, required 0");
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({IorD, mem_en, mem_we, if_done, ls_done, rdata, timeout_err} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: IorD=%0b mem_en=%0b mem_we=%0b if_done=%0b ls_done=%0b rdata=%h timeout_err=%0b, required all 0",
                     IorD, mem_en, mem_we, if_done, ls_done, rdata, timeout_err);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({IorD, mem_en, mem_we, if_done, ls_done, rdata, timeout_err} !== 38'd0) begin
            failures++;
            $display("FAIL idle_outputs: mem_en=%0b mem_we=%0b rdata=%h, required all 0", mem_en, mem_we, rdata);
        end
    endtask

    task automatic test_fetch_wait();
        int en_cycles = 0;
        int iord_bad = 0;
        int done_at = -1;
        mem_wait = 2;
        mem_data = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        if_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cycles++;
                if (IorD !== 1'b0) iord_bad++;
            end
            if (if_done) begin
                done_at = c;
                break;
            end
        end
        if_req = 1'b0;
        checks++;
        if (done_at != 4) begin
            failures++;
            $display("FAIL fetch_latency: done at cycle %0d, required 4", done_at);
        end
        checks++;
        if (en_cycles != 3) begin
            failures++;
            $display("FAIL fetch_en_cycles: %0d, required 3", en_cycles);
        end
        checks++;
        if (iord_bad != 0) begin
            failures++;
            $display("FAIL fetch_iord: %0d cycles with IorD!=0, required 0", iord_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        int we_cycles = 0;
        int iord_bad = 0;
        int done_at = -1;
        mem_wait = 0;
        mem_data = 32'h0BADF00D;
        exp_q.push_back('{1'b1, 32'h0BADF00D, 1'b0});
        ls_we = 1'b1;
        ls_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_we) we_cycles++;
            if (mem_en && IorD !== 1'b1) iord_bad++;
            if (ls_done) begin
                done_at = c;
                break;
            end
        end
        ls_req = 1'b0;
        ls_we = 1'b0;
        checks++;
        if (done_at != 2) begin
            failures++;
            $display("FAIL store_latency: done at cycle %0d, required 2", done_at);
        end
        checks++;
        if (we_cycles != 1 || iord_bad != 0) begin
            failures++;
            $display("FAIL store_strobes: mem_we cycles=%0d bad IorD=%0d, required 1 and 0", we_cycles, iord_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int en_cycles = 0;
        int done_at = -1;
        mem_wait = -1;
        mem_data = 32'h12345678;
        exp_q.push_back('{1'b1, 32'h0, 1'b1});
        ls_req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (mem_en) en_cycles++;
            if (ls_done) begin
                done_at = c;
                break;
            end
        end
        ls_req = 1'b0;
        checks++;
        if (en_cycles != 16) begin
            failures++;
            $display("FAIL timeout_en_cycles: %0d, required 16", en_cycles);
        end
        checks++;
        if (done_at != 17) begin
            failures++;
            $display("FAIL timeout_latency: done at cycle %0d, required 17", done_at);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int dones = 0;
        mem_wait = -1;
        ls_req = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || ls_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_access: mem_en=%0b ls_done=%0b, required 0 0", mem_en, ls_done);
        end
        ls_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_done || ls_done || mem_en) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_dropped_access: %0d active cycles after reset, required 0", dones);
        end
    endtask

    task automatic test_drop_after_grant();
        int seen = 0;
        int got_if = 0;
        apply_reset();
        grant_q.delete();
        mem_wait = 1;
        mem_data = 32'hCAFE0001;
        exp_q.push_back('{1'b1, 32'hCAFE0001, 1'b0});
        exp_q.push_back('{1'b0, 32'hCAFE0001, 1'b0});
        if_req = 1'b1;
        ls_req = 1'b1;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (mem_en) seen = 1;
        end
        @(negedge clk);
        ls_req = 1'b0;
        for (int c = 0; c < 40 && got_if == 0; c++) begin
            @(negedge clk);
            if (if_done) got_if = 1;
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_if != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drop_completion: if_done seen=%0d pending=%0d, required 1 and 0", got_if, exp_q.size());
        end
        checks++;
        if (grant_q.size() != 2 || grant_q[0] !== 1'b1 || grant_q[1] !== 1'b0) begin
            failures++;
            $display("FAIL drop_grant_order: %0d grants, required data then fetch", grant_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        logic want;
        apply_reset();
        grant_q.delete();
        mem_wait = 0;
        mem_data = 32'h5A5A0000;
        for (int i = 0; i < 10; i++) begin
            want = (i % 5) != 4;
            exp_q.push_back('{want, 32'h5A5A0000, 1'b0});
        end
        if_req = 1'b1;
        ls_req = 1'b1;
        for (int c = 0; c < 200 && dones < 10; c++) begin
            @(negedge clk);
            if (if_done || ls_done) dones++;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dones != 10 || grant_q.size() != 10) begin
            failures++;
            $display("FAIL b2b_count: dones=%0d grants=%0d, required 10 and 10", dones, grant_q.size());
        end
        for (int i = 0; i < grant_q.size() && i < 10; i++) begin
            want = (i % 5) != 4;
            checks++;
            if (grant_q[i] !== want) begin
                failures++;
                $display("FAIL b2b_grant_%0d: IorD=%0b, required %0b", i, grant_q[i], want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_drop_after_grant();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
